// File: rtl/router_pkg.sv
// Constants shared by the router ingress framer, the router FSM and the synchronizer:
// state encodings, header field layout and port addressing.
package router_pkg;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_LOAD    = 3'd1;
  localparam logic [2:0] ST_HEADER  = 3'd2;
  localparam logic [2:0] ST_PAYLOAD = 3'd3;
  localparam logic [2:0] ST_PARITY  = 3'd4;
  localparam logic [2:0] ST_GAP     = 3'd5;

  localparam int HDR_LEN_MSB = 7;
  localparam int HDR_LEN_LSB = 2;
  localparam int ADDR_W      = 2;
  localparam int LEN_W       = HDR_LEN_MSB - HDR_LEN_LSB + 1;

  localparam logic [ADDR_W-1:0] ADDR_INVALID = 2'b11;
  localparam int                MAX_PORT     = 2;

  typedef struct packed {
    logic [LEN_W-1:0]  len;
    logic [ADDR_W-1:0] addr;
  } pkt_hdr_t;

  function automatic logic [7:0] mk_header(input logic [LEN_W-1:0] len,
                                           input logic [ADDR_W-1:0] addr);
    pkt_hdr_t h;
    h.len  = len;
    h.addr = addr;
    return h;
  endfunction

endpackage

// File: rtl/router_pkt_framer_if.sv
// Host command/payload and router-facing signals of the packet framer.
// The framer uses the slave modport; the host/router environment uses master.
interface router_pkt_framer_if;
  import router_pkg::*;

  logic              cmd_valid;
  logic              cmd_ready;
  logic [ADDR_W-1:0] cmd_addr;
  logic [LEN_W-1:0]  cmd_len;
  logic              cmd_err;
  logic              pl_valid;
  logic [7:0]        pl_data;
  logic              pl_ready;
  logic              busy;
  logic              error;
  logic              pkt_valid;
  logic [7:0]        pkt_data;
  logic              done;
  logic              pkt_err;
  logic [7:0]        err_cnt;

  modport slave (
    input  cmd_valid, cmd_addr, cmd_len, pl_valid, pl_data, busy, error,
    output cmd_ready, cmd_err, pl_ready, pkt_valid, pkt_data, done, pkt_err, err_cnt
  );

  modport master (
    output cmd_valid, cmd_addr, cmd_len, pl_valid, pl_data, busy, error,
    input  cmd_ready, cmd_err, pl_ready, pkt_valid, pkt_data, done, pkt_err, err_cnt
  );

endinterface

// File: rtl/router_pl_buf.sv
// Payload byte store: synchronous write, combinational read, no reset on the array.
module router_pl_buf #(
  parameter int DEPTH = 63,
  parameter int AW    = 6
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    wdata,
  input  logic [AW-1:0] raddr,
  output logic [7:0]    rdata
);
  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  logic [7:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we && waddr <= LAST) mem[waddr] <= wdata;
  end

  assign rdata = (raddr <= LAST) ? mem[raddr] : 8'h00;

endmodule

// File: rtl/router_pkt_framer.sv
// Buffers a whole payload, then emits header, payload and parity to the router,
// honouring router busy and counting router-reported parity errors in the gap window.
module router_pkt_framer
  import router_pkg::*;
#(
  parameter int MAX_LEN    = 63,
  parameter int GAP_CYCLES = 3
) (
  input  logic                clk,
  input  logic                rstn,
  router_pkt_framer_if.slave  bus
);
  localparam int               GW       = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GW-1:0]    GAP_LAST = GW'(GAP_CYCLES - 1);
  localparam logic [LEN_W-1:0] LEN_MAX  = LEN_W'(MAX_LEN);

  logic [2:0]        state_q,     state_d;
  logic [LEN_W-1:0]  idx_q,       idx_d;
  logic [LEN_W-1:0]  len_q,       len_d;
  logic [ADDR_W-1:0] addr_q,      addr_d;
  logic [7:0]        parity_q,    parity_d;
  logic [GW-1:0]     gap_q,       gap_d;
  logic              gap_err_q,   gap_err_d;
  logic              cmd_ready_q, cmd_ready_d;
  logic              cmd_err_q,   cmd_err_d;
  logic              pl_ready_q,  pl_ready_d;
  logic              pkt_valid_q, pkt_valid_d;
  logic [7:0]        pkt_data_q,  pkt_data_d;
  logic              done_q,      done_d;
  logic              pkt_err_q,   pkt_err_d;
  logic [7:0]        err_cnt_q,   err_cnt_d;

  logic              buf_we;
  logic [LEN_W-1:0]  buf_raddr;
  logic [7:0]        buf_rdata;
  logic              cmd_bad;
  logic              err_seen;

  // Read port always looks one byte ahead of what is currently on pkt_data.
  assign buf_raddr = (state_q == ST_HEADER) ? '0 : idx_q + 1'b1;
  assign cmd_bad   = (bus.cmd_len == '0) || (bus.cmd_len > LEN_MAX) ||
                     (bus.cmd_addr == ADDR_INVALID);
  assign err_seen  = gap_err_q | bus.error;

  router_pl_buf #(.DEPTH(MAX_LEN), .AW(LEN_W)) u_buf (
    .clk   (clk),
    .we    (buf_we),
    .waddr (idx_q),
    .wdata (bus.pl_data),
    .raddr (buf_raddr),
    .rdata (buf_rdata)
  );

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    len_d       = len_q;
    addr_d      = addr_q;
    parity_d    = parity_q;
    gap_d       = gap_q;
    gap_err_d   = gap_err_q;
    cmd_ready_d = cmd_ready_q;
    cmd_err_d   = 1'b0;
    pl_ready_d  = pl_ready_q;
    pkt_valid_d = pkt_valid_q;
    pkt_data_d  = pkt_data_q;
    done_d      = 1'b0;
    pkt_err_d   = 1'b0;
    err_cnt_d   = err_cnt_q;
    buf_we      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        cmd_ready_d = 1'b1;
        if (bus.cmd_valid && cmd_ready_q) begin
          if (cmd_bad) begin
            cmd_err_d = 1'b1;
          end else begin
            addr_d      = bus.cmd_addr;
            len_d       = bus.cmd_len;
            parity_d    = mk_header(bus.cmd_len, bus.cmd_addr);
            idx_d       = '0;
            cmd_ready_d = 1'b0;
            pl_ready_d  = 1'b1;
            state_d     = ST_LOAD;
          end
        end
      end
      ST_LOAD: begin
        if (bus.pl_valid && pl_ready_q) begin
          buf_we   = 1'b1;
          parity_d = parity_q ^ bus.pl_data;
          idx_d    = idx_q + 1'b1;
          if (idx_q + 1'b1 == len_q) begin
            pl_ready_d  = 1'b0;
            idx_d       = '0;
            pkt_valid_d = 1'b1;
            pkt_data_d  = mk_header(len_q, addr_q);
            state_d     = ST_HEADER;
          end
        end
      end
      ST_HEADER: begin
        if (!bus.busy) begin
          pkt_data_d = buf_rdata;
          state_d    = ST_PAYLOAD;
        end
      end
      ST_PAYLOAD: begin
        if (!bus.busy) begin
          // Parity goes out with pkt_valid low right after the last payload byte.
          if (idx_q == len_q - 1'b1) begin
            pkt_valid_d = 1'b0;
            pkt_data_d  = parity_q;
            state_d     = ST_PARITY;
          end else begin
            idx_d      = idx_q + 1'b1;
            pkt_data_d = buf_rdata;
          end
        end
      end
      ST_PARITY: begin
        if (!bus.busy) begin
          pkt_data_d = 8'h00;
          gap_d      = '0;
          gap_err_d  = 1'b0;
          state_d    = ST_GAP;
        end
      end
      ST_GAP: begin
        gap_err_d = err_seen;
        gap_d     = gap_q + 1'b1;
        if (gap_q == GAP_LAST) begin
          done_d      = 1'b1;
          pkt_err_d   = err_seen;
          if (err_seen && err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
          cmd_ready_d = 1'b1;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      len_q       <= '0;
      addr_q      <= '0;
      parity_q    <= '0;
      gap_q       <= '0;
      gap_err_q   <= 1'b0;
      cmd_ready_q <= 1'b0;
      cmd_err_q   <= 1'b0;
      pl_ready_q  <= 1'b0;
      pkt_valid_q <= 1'b0;
      pkt_data_q  <= '0;
      done_q      <= 1'b0;
      pkt_err_q   <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      len_q       <= len_d;
      addr_q      <= addr_d;
      parity_q    <= parity_d;
      gap_q       <= gap_d;
      gap_err_q   <= gap_err_d;
      cmd_ready_q <= cmd_ready_d;
      cmd_err_q   <= cmd_err_d;
      pl_ready_q  <= pl_ready_d;
      pkt_valid_q <= pkt_valid_d;
      pkt_data_q  <= pkt_data_d;
      done_q      <= done_d;
      pkt_err_q   <= pkt_err_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign bus.cmd_ready = cmd_ready_q;
  assign bus.cmd_err   = cmd_err_q;
  assign bus.pl_ready  = pl_ready_q;
  assign bus.pkt_valid = pkt_valid_q;
  assign bus.pkt_data  = pkt_data_q;
  assign bus.done      = done_q;
  assign bus.pkt_err   = pkt_err_q;
  assign bus.err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_router_pkt_framer.sv
// Bench for router_pkt_framer: directed scenarios plus randomized traffic, checked every
// cycle against a transaction-level model of the expected router byte stream.
module tb_router_pkt_framer;
  import router_pkg::*;

  localparam int MAX_LEN = 63;
  localparam int GAP     = 3;

  logic clk  = 1'b0;
  logic rstn = 1'b0;

  router_pkt_framer_if bus();

  router_pkt_framer #(.MAX_LEN(MAX_LEN), .GAP_CYCLES(GAP)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Router-side stimulus: busy/error driven a little after each edge.
  int busy_force = 0;
  int busy_pct   = 0;
  int err_force  = 0;
  int err_pct    = 0;

  initial begin
    bus.busy  = 1'b0;
    bus.error = 1'b0;
    forever begin
      @(posedge clk); #2;
      bus.busy  = (busy_force >= 0) ? busy_force[0] : ($urandom_range(99) < busy_pct);
      bus.error = err_force[0] | ($urandom_range(99) < err_pct);
    end
  end

  // Transaction model: what the router must see, derived from accepted commands/payload.
  typedef struct packed { logic v; logic [7:0] d; } beat_t;
  beat_t       exp_q[$];
  logic [7:0]  pay[$];
  logic [7:0]  got_q[$];
  int          hdr_cyc = 0, err_pulses = 0;
  bit          first = 1'b1, active = 1'b0, loading = 1'b0, sending = 1'b0;
  bit          in_gap = 1'b0, err_due = 1'b0, gap_err = 1'b0;
  bit          exp_done, exp_perr, exp_crdy;
  int          pos = 0, gap_n = 0, mdl_errcnt = 0;
  logic [1:0]  c_addr;
  logic [5:0]  c_len;
  logic [7:0]  par;

  always @(negedge clk) begin
    if (!rstn) begin
      chk("rst_ctrl", {bus.cmd_ready, bus.pl_ready, bus.cmd_err, bus.pkt_valid, bus.done, bus.pkt_err}, 0);
      chk("rst_data", {bus.pkt_data, bus.err_cnt}, 0);
      first = 1'b1; active = 1'b0; loading = 1'b0; sending = 1'b0; in_gap = 1'b0;
      err_due = 1'b0; mdl_errcnt = 0; exp_q.delete(); pay.delete();
    end else begin
      exp_done = 1'b0;
      exp_perr = 1'b0;
      if (in_gap) begin
        gap_n++;
        if (gap_n <= GAP) gap_err |= bus.error;
        else begin
          exp_done = 1'b1;
          exp_perr = gap_err;
          if (gap_err && mdl_errcnt < 255) mdl_errcnt++;
          in_gap = 1'b0;
          active = 1'b0;
        end
      end
      chk("done", bus.done, exp_done);
      chk("pkt_err", bus.pkt_err, exp_perr);
      chk("err_cnt", bus.err_cnt, mdl_errcnt);
      exp_crdy = !first && !active;
      chk("cmd_ready", bus.cmd_ready, exp_crdy);
      chk("pl_ready", bus.pl_ready, loading);
      chk("cmd_err", bus.cmd_err, err_due);
      if (bus.cmd_err) err_pulses++;

      if (sending) begin
        chk("pkt_valid", bus.pkt_valid, exp_q[pos].v);
        chk("pkt_data", bus.pkt_data, exp_q[pos].d);
        if (pos == 0) hdr_cyc++;
        if (!bus.busy) begin
          got_q.push_back(bus.pkt_data);
          pos++;
          if (pos == exp_q.size()) begin
            sending = 1'b0; in_gap = 1'b1; gap_n = 0; gap_err = 1'b0;
          end
        end
      end else begin
        chk("idle_valid", bus.pkt_valid, 0);
        chk("idle_data", bus.pkt_data, 0);
      end

      err_due = 1'b0;
      if (bus.pl_valid && loading) begin
        pay.push_back(bus.pl_data);
        if (pay.size() == int'(c_len)) begin
          loading = 1'b0;
          exp_q.delete();
          par = {c_len, c_addr};
          exp_q.push_back({1'b1, par});
          foreach (pay[i]) begin
            exp_q.push_back({1'b1, pay[i]});
            par ^= pay[i];
          end
          exp_q.push_back({1'b0, par});
          sending = 1'b1;
          pos     = 0;
        end
      end
      if (bus.cmd_valid && exp_crdy) begin
        if (bus.cmd_len == 0 || int'(bus.cmd_len) > MAX_LEN || bus.cmd_addr == 2'd3) err_due = 1'b1;
        else begin
          active = 1'b1; loading = 1'b1;
          c_addr = bus.cmd_addr; c_len = bus.cmd_len;
          pay.delete();
        end
      end
      first = 1'b0;
    end
  end

  logic [7:0] pl_mem [64];

  function automatic logic [7:0] ref_parity(input logic [1:0] a, input logic [5:0] l);
    logic [7:0] p = {l, a};
    for (int i = 0; i < int'(l); i++) p ^= pl_mem[i];
    return p;
  endfunction

  task automatic host_pkt(input logic [1:0] a, input logic [5:0] l, input int bub, input bit junk);
    int n = 0;
    int i = 0;
    bit acc;
    bus.cmd_valid = 1'b1; bus.cmd_addr = a; bus.cmd_len = l;
    do begin
      acc = bus.cmd_ready;
      @(posedge clk); #1; n++;
    end while (!acc && n < 100 && rstn);
    bus.cmd_valid = 1'b0;
    n = 0;
    while (i < int'(l) && n < 2000 && rstn) begin
      bus.pl_valid = ($urandom_range(99) >= bub);
      bus.pl_data  = pl_mem[i];
      acc = bus.pl_valid && bus.pl_ready;
      @(posedge clk); #1; n++;
      if (acc) i++;
    end
    bus.pl_valid = 1'b0;
    n = 0;
    while (!bus.done && n < 3000 && rstn) begin
      if (junk) begin
        bus.cmd_valid = 1'($urandom_range(1));
        bus.cmd_addr  = 2'($urandom_range(3));
        bus.cmd_len   = 6'($urandom_range(63));
        bus.pl_valid  = 1'($urandom_range(1));
        bus.pl_data   = 8'($urandom);
      end
      @(posedge clk); #1; n++;
    end
    bus.cmd_valid = 1'b0;
    bus.pl_valid  = 1'b0;
    if (rstn) chk("done_seen", bus.done, 1);
  endtask

  task automatic host_bad(input logic [1:0] a, input logic [5:0] l);
    int n = 0;
    bit acc;
    bus.cmd_valid = 1'b1; bus.cmd_addr = a; bus.cmd_len = l;
    do begin
      acc = bus.cmd_ready;
      @(posedge clk); #1; n++;
    end while (!acc && n < 100);
    bus.cmd_valid = 1'b0;
    chk("bad_cmd_err", bus.cmd_err, 1);
    chk("bad_cmd_ready", bus.cmd_ready, 1);
    @(posedge clk); #1;
    chk("bad_cmd_err_clr", bus.cmd_err, 0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  int         base, hc0, ep0;
  logic [7:0] t1 [5];
  logic [7:0] p;

  initial begin
    bus.cmd_valid = 1'b0; bus.cmd_addr = '0; bus.cmd_len = '0;
    bus.pl_valid  = 1'b0; bus.pl_data  = '0;
    t1[0] = 8'h0D; t1[1] = 8'h11; t1[2] = 8'h22; t1[3] = 8'h33; t1[4] = 8'h0D;

    repeat (3) @(posedge clk);
    #1 rstn = 1'b1;
    chk("rel_cmd_ready_first", bus.cmd_ready, 0);
    @(posedge clk); #1;
    chk("rel_cmd_ready", bus.cmd_ready, 1);

    // Basic packet
    pl_mem[0] = 8'h11; pl_mem[1] = 8'h22; pl_mem[2] = 8'h33;
    base = got_q.size();
    host_pkt(2'd1, 6'd3, 0, 1'b0);
    chk("t1_nbytes", got_q.size() - base, 5);
    for (int i = 0; i < 5; i++) chk("t1_byte", got_q[base + i], t1[i]);
    chk("t1_err_cnt", bus.err_cnt, 0);

    // Header held under busy
    base = got_q.size();
    hc0  = hdr_cyc;
    fork
      host_pkt(2'd1, 6'd3, 0, 1'b0);
      begin : hold_busy
        int n = 0;
        while (!bus.pkt_valid && n < 200) begin @(posedge clk); #1; n++; end
        busy_force = 1;
        repeat (2) begin @(posedge clk); #1; end
        busy_force = 0;
      end
    join
    chk("t2_hdr_cycles", hdr_cyc - hc0, 3);
    chk("t2_nbytes", got_q.size() - base, 5);
    chk("t2_parity", got_q[base + 4], 8'h0D);

    // Rejected commands
    ep0 = err_pulses;
    host_bad(2'd3, 6'd5);
    host_bad(2'd1, 6'd0);
    chk("t3_err_pulses", err_pulses - ep0, 2);

    // Maximum length, bubbly payload
    for (int i = 0; i < 63; i++) pl_mem[i] = 8'($urandom);
    base = got_q.size();
    hc0  = hdr_cyc;
    host_pkt(2'd2, 6'd63, 50, 1'b0);
    chk("t4_nbytes", got_q.size() - base, 65);
    chk("t4_hdr", got_q[base], 8'hFE);
    chk("t4_hdr_cycles", hdr_cyc - hc0, 1);
    chk("t4_parity", got_q[base + 64], ref_parity(2'd2, 6'd63));

    // Router error during gap, with counter saturation
    err_force = 1;
    pl_mem[0] = 8'hA5;
    host_pkt(2'd0, 6'd1, 0, 1'b0);
    chk("t5_pkt_err", bus.pkt_err, 1);
    chk("t5_err_cnt1", bus.err_cnt, 1);
    for (int k = 0; k < 255; k++) host_pkt(2'($urandom_range(2)), 6'd1, 0, 1'b0);
    chk("t5_err_cnt_sat", bus.err_cnt, 255);
    err_force = 0;

    // Reset in the middle of the payload
    for (int i = 0; i < 10; i++) pl_mem[i] = 8'($urandom);
    base = got_q.size();
    fork
      host_pkt(2'd0, 6'd10, 0, 1'b0);
      begin : mid_reset
        int n = 0;
        while (got_q.size() - base < 6 && n < 300) begin @(posedge clk); #1; n++; end
        chk("t6_idx5_data", bus.pkt_data, pl_mem[5]);
        rstn = 1'b0;
        #1;
        chk("t6_rst_valid", bus.pkt_valid, 0);
        chk("t6_rst_data", bus.pkt_data, 0);
        @(posedge clk); @(posedge clk); #1;
        rstn = 1'b1;
      end
    join
    chk("t6_cmd_ready_first", bus.cmd_ready, 0);
    @(posedge clk); #1;
    chk("t6_cmd_ready", bus.cmd_ready, 1);
    chk("t6_err_cnt", bus.err_cnt, 0);
    for (int i = 0; i < 4; i++) pl_mem[i] = 8'($urandom);
    base = got_q.size();
    host_pkt(2'd2, 6'd4, 0, 1'b0);
    p = ref_parity(2'd2, 6'd4);
    chk("t6_nbytes", got_q.size() - base, 6);
    chk("t6_parity", got_q[base + 5], p);

    // Randomized traffic
    busy_force = -1; busy_pct = 30; err_pct = 10;
    for (int k = 0; k < 40; k++) begin
      if ($urandom_range(9) == 0) begin
        if ($urandom_range(1) == 0) host_bad(2'd3, 6'($urandom_range(1, 63)));
        else                        host_bad(2'($urandom_range(2)), 6'd0);
      end else begin
        int l;
        l = ($urandom_range(7) == 0) ? 63 : int'($urandom_range(1, 16));
        for (int i = 0; i < l; i++) pl_mem[i] = 8'($urandom);
        host_pkt(2'($urandom_range(2)), 6'(l), int'($urandom_range(60)), 1'b1);
      end
    end
    busy_force = 0; err_pct = 0;
    repeat (5) @(posedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
